// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with register-array
// storage, occupancy counter, full/empty/almost flags and a sticky
// overflow/underflow error flag.
//
// Optional build macro: FIFO_FWFT_EN
//   undefined (default): registered read, fifo_data_out updates one edge
//                        after an accepted pop, data_valid pulses for it.
//   defined            : first-word-fall-through, head word is shown
//                        combinationally whenever the FIFO is not empty.
//
// Status flags are registers updated from the next-state count, so they
// change on the edge after the causing push/pop and have no combinational
// path from push/pop.
module fifo_sync_param #(
    parameter int DATA_WIDTH      = 10,
    parameter int ADDR_WIDTH      = 3,
    parameter int ALMOST_FULL_TH  = 6,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_data_in,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  data_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  fifo_error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]         AF_TH_C = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0]         AE_TH_C = CW'(ALMOST_EMPTY_TH);
    localparam logic [CW-1:0]         ZERO_C  = CW'(0);
    localparam logic [CW-1:0]         ONE_C   = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);

    // Flag vector layout: {full, empty, almost_full, almost_empty}
    function automatic logic [3:0] decode_flags(input logic [CW-1:0] cnt);
        decode_flags = {(cnt == DEPTH_C), (cnt == ZERO_C),
                        (cnt >= AF_TH_C), (cnt <= AE_TH_C)};
    endfunction

    // Storage and bookkeeping state
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  afull_r;
    logic                  aempty_r;
    logic                  error_r;

    // Next-state decode
    logic                  pop_ok_s;
    logic                  push_ok_s;
    logic                  reject_s;
    logic [CW-1:0]         count_next_s;
    logic [3:0]            flags_next_s;

    // Request acceptance: a push into a full FIFO is allowed only when a pop
    // frees the head slot in the same cycle. Pop never succeeds while empty.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        reject_s  = 1'b0;
        if (pop && !empty_r) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (push && (!full_r || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
        if ((push && !push_ok_s) || (pop && !pop_ok_s)) begin
            reject_s = 1'b1;
        end else begin
            reject_s = 1'b0;
        end
    end

    // Occupancy update: push-only grows, pop-only shrinks, both/neither hold
    always_comb begin
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            2'b11:   count_next_s = count_r;
            2'b00:   count_next_s = count_r;
            default: count_next_s = count_r;
        endcase
        flags_next_s = decode_flags(count_next_s);
    end

    // Pointer, count, flag and sticky error registers; reset wins over requests
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= ZERO_C;
            {full_r, empty_r, afull_r, aempty_r} <= decode_flags(ZERO_C);
            error_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r  <= count_next_s;
            {full_r, empty_r, afull_r, aempty_r} <= flags_next_s;
            error_r  <= error_r | reject_s;
        end
    end

    // Storage write; the array is deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (push_ok_s && !reset) begin
            mem_r[wr_ptr_r] <= fifo_data_in;
        end
    end

    assign fifo_full    = full_r;
    assign fifo_empty   = empty_r;
    assign almost_full  = afull_r;
    assign almost_empty = aempty_r;
    assign fifo_count   = count_r;
    assign fifo_error   = error_r;

`ifdef FIFO_FWFT_EN
    // Head word falls through; pop only acknowledges what is already shown
    assign fifo_data_out = mem_r[rd_ptr_r];
    assign data_valid    = !empty_r;
`else
    logic [DATA_WIDTH-1:0] dout_r;
    logic                  valid_r;

    // Registered read: the word at rd_ptr is captured on the accepting edge.
    // With push+pop on a full FIFO the slot is read before it is overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_r  <= {DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else if (pop_ok_s) begin
            dout_r  <= mem_r[rd_ptr_r];
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign fifo_data_out = dout_r;
    assign data_valid    = valid_r;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Table-driven bench for fifo_sync_param in its default (registered read)
// build. Each record holds the inputs for one clock edge and the outputs
// expected just after that edge.
module tb_fifo_sync_param;

    logic       clk;
    logic       reset;
    logic [9:0] fifo_data_in;
    logic       push;
    logic       pop;
    logic [9:0] fifo_data_out;
    logic       data_valid;
    logic       fifo_full;
    logic       fifo_empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] fifo_count;
    logic       fifo_error;

    fifo_sync_param #(
        .DATA_WIDTH     (10),
        .ADDR_WIDTH     (3),
        .ALMOST_FULL_TH (6),
        .ALMOST_EMPTY_TH(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_data_in (fifo_data_in),
        .push         (push),
        .pop          (pop),
        .fifo_data_out(fifo_data_out),
        .data_valid   (data_valid),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_count   (fifo_count),
        .fifo_error   (fifo_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       psh;
        logic       pp;
        logic [9:0] din;
        int         cnt;
        logic       err;
        logic       vld;
        logic [9:0] dout;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    function automatic void add(input logic r, input logic ps, input logic pp,
                                input int din, input int cnt, input logic err,
                                input logic vld, input int dout);
        vec_t v;
        v.rst  = r;
        v.psh  = ps;
        v.pp   = pp;
        v.din  = 10'(din);
        v.cnt  = cnt;
        v.err  = err;
        v.vld  = vld;
        v.dout = 10'(dout);
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Flags come from a small independent model of the expected count
    task automatic chk_all(input int idx, input int cnt, input logic err,
                           input logic vld, input logic [9:0] dout);
        chk("fifo_count",   idx, int'(fifo_count),   cnt);
        chk("fifo_full",    idx, int'(fifo_full),    int'(cnt == 8));
        chk("fifo_empty",   idx, int'(fifo_empty),   int'(cnt == 0));
        chk("almost_full",  idx, int'(almost_full),  int'(cnt >= 6));
        chk("almost_empty", idx, int'(almost_empty), int'(cnt <= 2));
        chk("fifo_error",   idx, int'(fifo_error),   int'(err));
        chk("data_valid",   idx, int'(data_valid),   int'(vld));
        chk("fifo_data_out",idx, int'(fifo_data_out),int'(dout));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // ---- vector table: rst, push, pop, din, count, err, valid, dout ----
        for (int k = 1; k <= 8; k++) add(1'b0, 1'b1, 1'b0, k, k, 1'b0, 1'b0, 0);
        add(1'b0, 1'b1, 1'b0, 'h3FF, 8, 1'b1, 1'b0, 0);           // overflow
        for (int j = 1; j <= 8; j++) add(1'b0, 1'b0, 1'b1, 0, 8 - j, 1'b1, 1'b1, j);
        add(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 8);                // idle, dout held
        add(1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 8);                // underflow
        add(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);                // reset clears
        // wrap-around: advance pointers by 5, then fill across the wrap
        for (int k = 0; k < 5; k++) add(1'b0, 1'b1, 1'b0, 'h011 + k, k + 1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 5; k++) add(1'b0, 1'b0, 1'b1, 0, 4 - k, 1'b0, 1'b1, 'h011 + k);
        for (int k = 0; k < 8; k++) add(1'b0, 1'b1, 1'b0, 'h100 + k, k + 1, 1'b0, 1'b0, 'h015);
        for (int k = 0; k < 8; k++) add(1'b0, 1'b0, 1'b1, 0, 7 - k, 1'b0, 1'b1, 'h100 + k);
        // simultaneous push+pop while full (shared slot read before write)
        for (int k = 0; k < 8; k++) add(1'b0, 1'b1, 1'b0, 'h021 + k, k + 1, 1'b0, 1'b0, 'h107);
        add(1'b0, 1'b1, 1'b1, 'h2AA, 8, 1'b0, 1'b1, 'h021);
        for (int k = 0; k < 7; k++) add(1'b0, 1'b0, 1'b1, 0, 7 - k, 1'b0, 1'b1, 'h022 + k);
        add(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 'h2AA);
        // simultaneous push+pop while empty: push in, pop rejected
        add(1'b0, 1'b1, 1'b1, 'h155, 1, 1'b1, 1'b0, 'h2AA);
        // mid-stream reset with push asserted
        add(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 4; k++) add(1'b0, 1'b1, 1'b0, 'h031 + k, k + 1, 1'b0, 1'b0, 0);
        add(1'b1, 1'b1, 1'b0, 'h035, 0, 1'b0, 1'b0, 0);
        add(1'b0, 1'b1, 1'b0, 'h0F0, 1, 1'b0, 1'b0, 0);
        add(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 'h0F0);

        // ---- hand sequence: reset then three idle cycles ----
        reset        = 1'b1;
        push         = 1'b0;
        pop          = 1'b0;
        fifo_data_in = 10'h000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all(-1, 0, 1'b0, 1'b0, 10'h000);

        // ---- hand sequence: flags lag one edge behind the request ----
        push = 1'b1;
        fifo_data_in = 10'h0AA;
        #2;
        chk("empty_before_edge", -2, int'(fifo_empty), 1);
        @(posedge clk);
        #1;
        push = 1'b0;
        chk("empty_after_edge", -2, int'(fifo_empty), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_all(-3, 0, 1'b0, 1'b0, 10'h000);

        // ---- table-driven vectors ----
        for (int i = 0; i < vecs.size(); i++) begin
            reset        = vecs[i].rst;
            push         = vecs[i].psh;
            pop          = vecs[i].pp;
            fifo_data_in = vecs[i].din;
            @(posedge clk);
            #1;
            chk_all(i, vecs[i].cnt, vecs[i].err, vecs[i].vld, vecs[i].dout);
        end

        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
